// File: rtl/tetris_pkg.sv
// tetris_pkg: board constants, piece and FSM enums, tetromino shape ROM.
// Shape offsets are {dx[1:0], dy[1:0]} inside a 4x4 box, y counting up.
package tetris_pkg;

  localparam int W = 10;
  localparam int H = 12;

  typedef enum logic [2:0] {
    P_I, P_O, P_T, P_S, P_Z, P_J, P_L
  } piece_e;

  typedef enum logic [1:0] {
    S_IDLE, S_CHECK, S_FALL, S_OVER
  } state_e;

  typedef enum logic [2:0] {
    A_NONE, A_ROT, A_LEFT, A_RIGHT, A_GRAV
  } act_e;

  typedef struct packed {
    piece_e             typ;
    logic [1:0]         rot;
    logic signed [4:0]  ox;
    logic signed [4:0]  oy;
  } piece_t;

  typedef logic [0:6][0:3][3:0]       base_t;
  typedef logic [0:6][0:3][0:3][3:0]  rom_t;

  localparam base_t BASE = {
    4'h0, 4'h4, 4'h8, 4'hC,
    4'h4, 4'h8, 4'h5, 4'h9,
    4'h0, 4'h4, 4'h8, 4'h5,
    4'h0, 4'h4, 4'h5, 4'h9,
    4'h4, 4'h8, 4'h1, 4'h5,
    4'h0, 4'h4, 4'h8, 4'h1,
    4'h0, 4'h4, 4'h8, 4'h9
  };

  // Each rotation turns the box a quarter: (x,y) -> (y, 3-x).
  function automatic rom_t build_rom();
    rom_t       rom;
    logic [1:0] dx, dy, tmp;
    rom = '0;
    for (int t = 0; t < 7; t++) begin
      for (int k = 0; k < 4; k++) begin
        dx = BASE[t][k][3:2];
        dy = BASE[t][k][1:0];
        for (int r = 0; r < 4; r++) begin
          rom[t][r][k] = {dx, dy};
          tmp = dy;
          dy  = 2'd3 - dx;
          dx  = tmp;
        end
      end
    end
    return rom;
  endfunction

  localparam rom_t SHAPE = build_rom();

endpackage

// File: rtl/piece_collision.sv
// piece_collision: flags a candidate placement as legal when all four
// cells are on the board and unoccupied.
import tetris_pkg::*;

module piece_collision #(
  parameter int BOARD_W = W,
  parameter int BOARD_H = H
) (
  input  logic [3:0][5:0]                cx_i,
  input  logic [3:0][5:0]                cy_i,
  input  logic [BOARD_H-1:0][BOARD_W-1:0] rows_i,
  output logic                           legal_o
);

  logic signed [5:0] sx, sy;

  always_comb begin
    legal_o = 1'b1;
    sx      = '0;
    sy      = '0;
    for (int k = 0; k < 4; k++) begin
      sx = $signed(cx_i[k]);
      sy = $signed(cy_i[k]);
      if (sx < 0 || sx >= BOARD_W ||
          sy < 0 || sy >= BOARD_H) begin
        legal_o = 1'b0;
      end else if (rows_i[sy[3:0]][sx[3:0]]) begin
        legal_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/piece_mover.sv
// piece_mover: active tetromino FSM - spawn, moves, gravity, landing.
// Optional hard drop is built in when HARD_DROP_EN is defined.
import tetris_pkg::*;

module piece_mover #(
  parameter int         BOARD_W   = 10,
  parameter int         BOARD_H   = 12,
  parameter int         SPAWN_X   = 3,
  parameter int         SPAWN_Y   = 8,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               gen_flag,
  input  logic               tick,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_rotate,
  input  logic               btn_drop,
  input  logic [BOARD_W-1:0] arr0,
  input  logic [BOARD_W-1:0] arr1,
  input  logic [BOARD_W-1:0] arr2,
  input  logic [BOARD_W-1:0] arr3,
  input  logic [BOARD_W-1:0] arr4,
  input  logic [BOARD_W-1:0] arr5,
  input  logic [BOARD_W-1:0] arr6,
  input  logic [BOARD_W-1:0] arr7,
  input  logic [BOARD_W-1:0] arr8,
  input  logic [BOARD_W-1:0] arr9,
  input  logic [BOARD_W-1:0] arr10,
  input  logic [BOARD_W-1:0] arr11,
  output logic [3:0]         x1,
  output logic [3:0]         y1,
  output logic [3:0]         x2,
  output logic [3:0]         y2,
  output logic [3:0]         x3,
  output logic [3:0]         y3,
  output logic [3:0]         x4,
  output logic [3:0]         y4,
  output logic               bottom_flag,
  output logic               top_flag,
  output logic [2:0]         piece_type,
  output logic               active
);

  state_e          state_q;
  piece_t          pc_q;
  piece_t          cand;
  piece_t          spawn;
  act_e            act;
  logic [7:0]      lfsr_q;
  logic            pend_q;
  logic            drop_go;
  logic            legal;
  logic            bot_q, top_q, act_q;
  logic [3:0]      off;
  logic [3:0][3:0] xs_q, ys_q;
  logic [3:0][5:0] cx, cy;
  logic [BOARD_H-1:0][BOARD_W-1:0] rows;

  assign rows = {arr11, arr10, arr9, arr8,
                 arr7, arr6, arr5, arr4,
                 arr3, arr2, arr1, arr0};

`ifdef HARD_DROP_EN
  logic drop_q;
  assign drop_go = btn_drop | drop_q;
`else
  logic unused_drop;
  assign unused_drop = btn_drop;
  assign drop_go     = 1'b0;
`endif

  always_comb begin
    spawn.typ = (lfsr_q[2:0] == 3'd7) ? P_I
                                      : piece_e'(lfsr_q[2:0]);
    spawn.rot = 2'd0;
    spawn.ox  = 5'(SPAWN_X);
    spawn.oy  = 5'(SPAWN_Y);
  end

  always_comb begin
    act = A_NONE;
    if (state_q == S_FALL) begin
      if (drop_go)             act = A_GRAV;
      else if (btn_rotate)     act = A_ROT;
      else if (btn_left)       act = A_LEFT;
      else if (btn_right)      act = A_RIGHT;
      else if (tick | pend_q)  act = A_GRAV;
    end
  end

  // One candidate placement per cycle feeds the single collision check.
  always_comb begin
    cand = pc_q;
    off  = '0;
    cx   = '0;
    cy   = '0;
    unique case (state_q)
      S_IDLE, S_OVER: cand = spawn;
      default: ;
    endcase
    unique case (act)
      A_ROT:   cand.rot = pc_q.rot + 2'd1;
      A_LEFT:  cand.ox  = pc_q.ox - 5'sd1;
      A_RIGHT: cand.ox  = pc_q.ox + 5'sd1;
      A_GRAV:  cand.oy  = pc_q.oy - 5'sd1;
      default: ;
    endcase
    for (int k = 0; k < 4; k++) begin
      off   = SHAPE[cand.typ][cand.rot][k];
      cx[k] = {cand.ox[4], cand.ox} + 6'(off[3:2]);
      cy[k] = {cand.oy[4], cand.oy} + 6'(off[1:0]);
    end
  end

  piece_collision #(
    .BOARD_W (BOARD_W),
    .BOARD_H (BOARD_H)
  ) u_coll (
    .cx_i    (cx),
    .cy_i    (cy),
    .rows_i  (rows),
    .legal_o (legal)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      lfsr_q  <= LFSR_SEED;
      pend_q  <= 1'b0;
      xs_q    <= '0;
      ys_q    <= '0;
      bot_q   <= 1'b0;
      top_q   <= 1'b0;
      act_q   <= 1'b0;
`ifdef HARD_DROP_EN
      drop_q  <= 1'b0;
`endif
    end else begin
      lfsr_q <= {lfsr_q[6:0],
                 lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      bot_q  <= 1'b0;
      pend_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_OVER: begin
          if (gen_flag) begin
            pc_q    <= cand;
            top_q   <= 1'b0;
            state_q <= S_CHECK;
            for (int k = 0; k < 4; k++) begin
              xs_q[k] <= cx[k][3:0];
              ys_q[k] <= cy[k][3:0];
            end
          end
        end
        S_CHECK: begin
          if (legal) begin
            state_q <= S_FALL;
            act_q   <= 1'b1;
          end else begin
            state_q <= S_OVER;
            top_q   <= 1'b1;
          end
        end
        S_FALL: begin
          // A tick that loses arbitration waits; repeats coalesce.
          pend_q <= (act == A_GRAV) ? 1'b0 : (pend_q | tick);
`ifdef HARD_DROP_EN
          drop_q <= drop_go;
`endif
          if (act == A_GRAV && !legal) begin
            bot_q   <= 1'b1;
            act_q   <= 1'b0;
            state_q <= S_IDLE;
`ifdef HARD_DROP_EN
            drop_q  <= 1'b0;
`endif
          end else if (act != A_NONE && legal) begin
            pc_q <= cand;
            for (int k = 0; k < 4; k++) begin
              xs_q[k] <= cx[k][3:0];
              ys_q[k] <= cy[k][3:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign x1          = xs_q[0];
  assign y1          = ys_q[0];
  assign x2          = xs_q[1];
  assign y2          = ys_q[1];
  assign x3          = xs_q[2];
  assign y3          = ys_q[2];
  assign x4          = xs_q[3];
  assign y4          = ys_q[3];
  assign bottom_flag = bot_q;
  assign top_flag    = top_q;
  assign piece_type  = pc_q.typ;
  assign active      = act_q;

endmodule

// File: doc/piece_mover.md
# piece_mover

Active-tetromino controller feeding the game board stage. On each `gen_flag` it spawns a new piece, then applies gravity ticks and player moves against the board occupancy rows. It outputs the four cell coordinates continuously. When the piece can fall no further it pulses `bottom_flag` so the board latches the piece, and it raises `top_flag` when a spawn collides with the stack.

## Interface
Parameters:
- `BOARD_W`, 10: columns; x = 0..9.
- `BOARD_H`, 12: rows; y = 0 is bottom, 11 is top.
- `SPAWN_X`, 3: x origin of the 4x4 piece box at spawn.
- `SPAWN_Y`, 8: y origin (bottom-left) of the box at spawn.
- `LFSR_SEED`, 8'hA5: nonzero LFSR reset value.

Ports:
- `Clk` in 1: single clock.
- `Reset_n` in 1: reset, asynchronous and active-low.
- `gen_flag` in 1: spawn request, one cycle.
- `tick` in 1: gravity pulse, one cycle.
- `btn_left`, `btn_right`, `btn_rotate`, `btn_drop` in 1 each: debounced single-cycle pulses.
- `arr0`..`arr11` in 10 each: board rows; `arrY[x]` = 1 means cell (x,Y) is occupied.
- `x1,y1,x2,y2,x3,y3,x4,y4` out 4 each: active cell coordinates.
- `bottom_flag` out 1: landing pulse.
- `top_flag` out 1: spawn-collision level.
- `piece_type` out 3: 0 I, 1 O, 2 T, 3 S, 4 Z, 5 J, 6 L.
- `active` out 1: high in FALL.

## Operation
- Piece state: type (3 b), rot (2 b), origin ox, oy (signed 5 b). Cell k = (ox+dx_k, oy+dy_k), with dx, dy ∈ 0..3 taken from the shape ROM indexed by {type, rot}.
- A cell is illegal if x<0, x>9, y<0, y>11, or the board has it occupied. A move is legal only if all four candidate cells are legal.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4, free-running every cycle. At spawn, type = lfsr[2:0], with 7 mapped to 0.
- FSM states: IDLE, CHECK, FALL, OVER.
  - IDLE: on `gen_flag`, load type, rot=0, ox=SPAWN_X, oy=SPAWN_Y, and go to CHECK.
  - CHECK: if the spawn cells are illegal, go to OVER and set `top_flag`=1. Otherwise go to FALL.
  - FALL: service at most one action per cycle, in priority order drop > rotate > left > right > gravity.
    - Rotate: rot+1 mod 4, no wall kicks.
    - Left/right: ox∓1.
    - Gravity: oy−1.
    - Any illegal action is discarded with no state change.
    - Gravity that is illegal means the piece lands: pulse `bottom_flag` for 1 cycle with coordinates unchanged, then go to IDLE.
  - OVER: hold `top_flag`=1. A `gen_flag` clears it and performs an IDLE spawn.
- A `tick` arriving while a higher-priority action is serviced is held in a pending bit. The pending bit is serviced the next free FALL cycle; multiple ticks coalesce into one.
- Other button pulses that lose arbitration are dropped.
- Button pulses and ticks in IDLE, CHECK, or OVER are ignored, and pending is cleared.

## Timing
- Reset values:
  - All coordinates 0, `bottom_flag` 0, `top_flag` 0, `piece_type` 0, `active` 0.
  - FSM in IDLE, pending 0, LFSR=LFSR_SEED.
  - Reset takes effect immediately, including mid-fall, and discards the piece.
- All outputs are registered.
  - Coordinates are valid the cycle after the edge that samples `gen_flag`.
  - `top_flag` or `active` is valid 2 cycles after `gen_flag`.
- A legal move is visible on the coordinate outputs 1 cycle after the input pulse.
- `bottom_flag` is exactly 1 cycle, during which coordinates equal the landed position. Coordinates then hold until the next spawn.
- `gen_flag` in FALL is ignored.

## Configuration
- `HARD_DROP_EN` defined: `btn_drop` sets a drop latch. While latched, FALL applies gravity every cycle and ignores other inputs until landing. The latch clears on `bottom_flag` and on reset.
- `HARD_DROP_EN` undefined: `btn_drop` is ignored and no latch logic is generated.

## Structure
- Package `tetris_pkg`:
  - Board constants W=10, H=12.
  - Piece-type enum.
  - Shape ROM of 7×4 rotations × 4 (dx,dy) offsets.
  - FSM state enum.
- Sub-module `piece_collision`: combinational. Inputs are four candidate (x,y) pairs plus the rows; output is `legal`. It is instantiated once, fed by a candidate mux selected by the winning action.

## Test plan
- Reset, empty board, `gen_flag` → `piece_type`=5 (seed 8'hA5 → lfsr[2:0]=5), min y=8, `active`=1 two cycles later. Then 20 ticks → one `bottom_flag` pulse with min y=0, coordinates stable, then IDLE.
- Empty board, 12 `btn_left` pulses → min x settles at 0 with no wrap. 12 `btn_right` → max x=9.
- arr0..arr3=10'h3FF, spawn, ticks until landing → `bottom_flag` with min y=4, never overlapping an occupied cell.
- arr8..arr11=10'h3FF, `gen_flag` → `top_flag`=1 two cycles later, `bottom_flag` stays 0. Second `gen_flag` on a cleared board → `top_flag`=0.
- `tick` and `btn_left` in the same cycle → x decrements that cycle; y decrements the following cycle.
- `Reset_n` low mid-fall → all outputs 0 asynchronously. With `HARD_DROP_EN`, `btn_drop` on an empty board → `bottom_flag` within 9 cycles, min y=0.
